// File: rtl/video_pkg.sv
// Shared types and standard timing constants for the video scanout path.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // One raster axis, in pixels (horizontal) or lines (vertical).
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } video_timing_t;

    localparam video_timing_t TIMING_320X200_H = '{active: 16'd320, front: 16'd8,  sync: 16'd32, back: 16'd40};
    localparam video_timing_t TIMING_320X200_V = '{active: 16'd200, front: 16'd3,  sync: 16'd4,  back: 16'd6};
    localparam video_timing_t TIMING_640X480_H = '{active: 16'd640, front: 16'd16, sync: 16'd96, back: 16'd48};
    localparam video_timing_t TIMING_640X480_V = '{active: 16'd480, front: 16'd10, sync: 16'd2,  back: 16'd33};

    function automatic int timing_total(video_timing_t t);
        return int'(t.active) + int'(t.front) + int'(t.sync) + int'(t.back);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// Wrapping raster counter for one axis, with active-area and sync-window decode.
module video_axis_counter
    import video_pkg::*;
#(
    parameter video_timing_t TIMING = TIMING_320X200_H,
    parameter int            W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL      = timing_total(TIMING);
    localparam int SYNC_START = int'(TIMING.active) + int'(TIMING.front);
    localparam int SYNC_END   = SYNC_START + int'(TIMING.sync);

    assign wrap   = (cnt == W'(TOTAL - 1));
    assign active = (cnt < W'(int'(TIMING.active)));
    assign sync   = (cnt >= W'(SYNC_START)) && (cnt < W'(SYNC_END));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/video_scanout.sv
// Video timing generator and scanout engine: requests pixels, registers the returned RGB.
// Optional vertical-blank interrupt and frame counter: define VIDEO_SCANOUT_IRQ_EN.
module video_scanout
    import video_pkg::*;
#(
    parameter int H_ACTIVE      = 320,
    parameter int H_FRONT       = 8,
    parameter int H_SYNC        = 32,
    parameter int H_BACK        = 40,
    parameter int V_ACTIVE      = 200,
    parameter int V_FRONT       = 3,
    parameter int V_SYNC        = 4,
    parameter int V_BACK        = 6,
    parameter int CLK_PER_PIXEL = 16,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_video_request,
    output logic [8:0]  o_video_pos_x,
    output logic [8:0]  o_video_pos_y,
    input  logic [31:0] i_video_rdata,
    output rgb_t        o_rgb,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_vblank_irq
);

    localparam int CNT_W = 10;
    localparam int DIV_W = $clog2(CLK_PER_PIXEL);

    localparam video_timing_t H_TIMING = '{active: 16'(H_ACTIVE), front: 16'(H_FRONT),
                                           sync:   16'(H_SYNC),   back:  16'(H_BACK)};
    localparam video_timing_t V_TIMING = '{active: 16'(V_ACTIVE), front: 16'(V_FRONT),
                                           sync:   16'(V_SYNC),   back:  16'(V_BACK)};

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             tick_d;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active;
    logic             h_sync, v_sync;
    logic             hsync_req, vsync_req;

    assign tick = (div == DIV_W'(CLK_PER_PIXEL - 1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
        end
    end

    video_axis_counter #(.TIMING(H_TIMING), .W(CNT_W)) u_h_counter (
        .clk    (i_clock),
        .rst_n  (i_reset_n),
        .en     (tick),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    video_axis_counter #(.TIMING(V_TIMING), .W(CNT_W)) u_v_counter (
        .clk    (i_clock),
        .rst_n  (i_reset_n),
        .en     (tick && h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Request stage: registered copy of the counters, so each pixel is presented
    // for a full period and the capture edge is the one closing that period.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_video_request <= 1'b0;
            o_video_pos_x   <= '0;
            o_video_pos_y   <= '0;
            hsync_req       <= 1'b0;
            vsync_req       <= 1'b0;
            tick_d          <= 1'b0;
        end else begin
            o_video_request <= h_active && v_active;
            o_video_pos_x   <= (h_active && v_active) ? h_cnt[8:0] : 9'd0;
            o_video_pos_y   <= (h_active && v_active) ? v_cnt[8:0] : 9'd0;
            hsync_req       <= h_sync;
            vsync_req       <= v_sync;
            tick_d          <= tick;
        end
    end

    // Output stage: blind capture of the returned pixel plus the delayed syncs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rgb   <= '0;
            o_de    <= 1'b0;
            o_hsync <= ~HSYNC_POL;
            o_vsync <= ~VSYNC_POL;
        end else if (tick_d) begin
            o_rgb   <= o_video_request ? rgb_t'(i_video_rdata[23:0]) : '0;
            o_de    <= o_video_request;
            o_hsync <= hsync_req ? HSYNC_POL : ~HSYNC_POL;
            o_vsync <= vsync_req ? VSYNC_POL : ~VSYNC_POL;
        end
    end

`ifdef VIDEO_SCANOUT_IRQ_EN
    logic        vblank_start;
    logic [15:0] frame_cnt;
    logic        unused_frame_cnt;

    assign vblank_start     = tick && h_wrap && (v_cnt == CNT_W'(V_ACTIVE - 1));
    assign unused_frame_cnt = ^frame_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_vblank_irq <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            o_vblank_irq <= vblank_start;
            if (vblank_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`else
    assign o_vblank_irq = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{i_video_rdata[31:24], v_wrap, h_cnt[CNT_W-1:9], v_cnt[CNT_W-1:9]};

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout on a small raster (H 8/2/3/2, V 4/1/2/1, 4 clocks/pixel).
module tb_video_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int CPP   = 4;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int LINE  = HT * CPP;
    localparam int FRAME = VT * LINE;
    localparam bit HPOL  = 1'b0;
    localparam bit VPOL  = 1'b0;

    logic        i_clock   = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        o_video_request;
    logic [8:0]  o_video_pos_x, o_video_pos_y;
    logic [31:0] i_video_rdata;
    logic [23:0] o_rgb;
    logic        o_de, o_hsync, o_vsync, o_vblank_irq;

    video_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_PER_PIXEL(CPP), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .i_clock         (i_clock),
        .i_reset_n       (i_reset_n),
        .o_video_request (o_video_request),
        .o_video_pos_x   (o_video_pos_x),
        .o_video_pos_y   (o_video_pos_y),
        .i_video_rdata   (i_video_rdata),
        .o_rgb           (o_rgb),
        .o_de            (o_de),
        .o_hsync         (o_hsync),
        .o_vsync         (o_vsync),
        .o_vblank_irq    (o_vblank_irq)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic        alt_mode = 1'b0;
    logic [31:0] alt_word;

    // Clocks since reset release; the whole reference model is derived from this.
    always @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Video-mode responder: echo of {y,x}, or a value that changes every clock.
    assign alt_word      = 32'(cyc) * 32'h9E37_79B1;
    assign i_video_rdata = alt_mode ? alt_word : {14'h0, o_video_pos_y, o_video_pos_x};

    typedef struct {
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_exp;
    exp_t new_exp;
    int   m_p, m_ph, m_h, m_v;
    logic m_act;

    // Scoreboard monitor: pushes the expected output when a request period closes,
    // pops it when the next pixel period starts, and checks every clock.
    always @(negedge i_clock) begin
        if (!i_reset_n) begin
            sb_q.delete();
            cur_exp = '{de: 1'b0, rgb: 24'h0, hs: ~HPOL, vs: ~VPOL};
        end else if (cyc >= 1) begin
            m_p   = (cyc - 1) / CPP;
            m_ph  = (cyc - 1) % CPP;
            m_h   = m_p % HT;
            m_v   = (m_p / HT) % VT;
            m_act = (m_h < HA) && (m_v < VA);
            n_checks++;
            if (o_video_request !== m_act ||
                o_video_pos_x !== (m_act ? 9'(m_h) : 9'd0) ||
                o_video_pos_y !== (m_act ? 9'(m_v) : 9'd0)) begin
                n_fail++;
                $display("FAIL request_pos cyc=%0d got req=%b x=%0d y=%0d expected req=%b x=%0d y=%0d",
                         cyc, o_video_request, o_video_pos_x, o_video_pos_y,
                         m_act, m_act ? m_h : 0, m_act ? m_v : 0);
            end
            if (m_ph == 0 && sb_q.size() > 0) cur_exp = sb_q.pop_front();
            n_checks++;
            if (o_de !== cur_exp.de || o_rgb !== cur_exp.rgb ||
                o_hsync !== cur_exp.hs || o_vsync !== cur_exp.vs) begin
                n_fail++;
                $display("FAIL pixel_out cyc=%0d got de=%b rgb=%h hs=%b vs=%b expected de=%b rgb=%h hs=%b vs=%b",
                         cyc, o_de, o_rgb, o_hsync, o_vsync,
                         cur_exp.de, cur_exp.rgb, cur_exp.hs, cur_exp.vs);
            end
            if (m_ph == CPP - 1) begin
                new_exp.de  = m_act;
                new_exp.rgb = !m_act ? 24'h0 : (alt_mode ? alt_word[23:0] : {6'h0, 9'(m_v), 9'(m_h)});
                new_exp.hs  = (m_h >= HA + HF && m_h < HA + HF + HS) ? HPOL : ~HPOL;
                new_exp.vs  = (m_v >= VA + VF && m_v < VA + VF + VS) ? VPOL : ~VPOL;
                sb_q.push_back(new_exp);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (o_video_request !== 1'b0 || o_video_pos_x !== 9'd0 || o_video_pos_y !== 9'd0 ||
            o_rgb !== 24'h0 || o_de !== 1'b0 || o_hsync !== ~HPOL || o_vsync !== ~VPOL ||
            o_vblank_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got req=%b x=%0d y=%0d rgb=%h de=%b hs=%b vs=%b irq=%b expected all idle, syncs inactive",
                     tag, o_video_request, o_video_pos_x, o_video_pos_y, o_rgb, o_de,
                     o_hsync, o_vsync, o_vblank_irq);
        end
    endtask

    task automatic release_and_check_start(input string tag);
        int guard;
        @(posedge i_clock); #2 i_reset_n = 1'b1;
        @(posedge i_clock); #1;
        n_checks++;
        if (o_video_request !== 1'b1 || o_video_pos_x !== 9'd0 || o_video_pos_y !== 9'd0) begin
            n_fail++;
            $display("FAIL %s_first_request got req=%b x=%0d y=%0d expected req=1 x=0 y=0",
                     tag, o_video_request, o_video_pos_x, o_video_pos_y);
        end
        guard = 0;
        while (o_de !== 1'b1 && guard < 4 * CPP) begin
            @(posedge i_clock); #1;
            guard++;
        end
        n_checks++;
        if (o_de !== 1'b1 || cyc - 1 != CPP) begin
            n_fail++;
            $display("FAIL %s_first_de got de=%b after %0d clocks expected de=1 after %0d clocks",
                     tag, o_de, cyc - 1, CPP);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clock);
        #1 check_reset_values("reset_state");
        release_and_check_start("reset");
    endtask

    task automatic test_sync_period();
        int   t[2];
        int   found;
        logic prev;
        for (int k = 0; k < 2; k++) begin
            found = 0;
            for (int g = 0; g < 2 * LINE && found == 0; g++) begin
                prev = o_hsync;
                @(negedge i_clock);
                if (prev === ~HPOL && o_hsync === HPOL) begin
                    found = 1;
                    t[k]  = cyc;
                end
            end
            if (found == 0) t[k] = -1;
        end
        n_checks++;
        if (t[0] < 0 || t[1] < 0 || t[1] - t[0] != LINE) begin
            n_fail++;
            $display("FAIL hsync_period got %0d clocks expected %0d", t[1] - t[0], LINE);
        end
        for (int k = 0; k < 2; k++) begin
            found = 0;
            for (int g = 0; g < 2 * FRAME && found == 0; g++) begin
                prev = o_vsync;
                @(negedge i_clock);
                if (prev === ~VPOL && o_vsync === VPOL) begin
                    found = 1;
                    t[k]  = cyc;
                end
            end
            if (found == 0) t[k] = -1;
        end
        n_checks++;
        if (t[0] < 0 || t[1] < 0 || t[1] - t[0] != FRAME) begin
            n_fail++;
            $display("FAIL vsync_period got %0d clocks expected %0d", t[1] - t[0], FRAME);
        end
    endtask

    task automatic test_de_counts();
        int   de_clks = 0, req_clks = 0, run = 0, max_run = 0, rises = 0;
        logic prev;
        @(negedge i_clock);
        prev = o_de;
        for (int g = 0; g < FRAME; g++) begin
            @(negedge i_clock);
            if (o_de === 1'b1) de_clks++;
            if (o_video_request === 1'b1) req_clks++;
            if (prev !== 1'b1 && o_de === 1'b1) rises++;
            run     = (o_de === 1'b1) ? run + 1 : 0;
            max_run = (run > max_run) ? run : max_run;
            prev    = o_de;
        end
        n_checks++;
        if (de_clks != HA * VA * CPP || req_clks != HA * VA * CPP) begin
            n_fail++;
            $display("FAIL frame_active_clocks got de=%0d req=%0d expected %0d",
                     de_clks, req_clks, HA * VA * CPP);
        end
        n_checks++;
        if (max_run != HA * CPP || rises != VA) begin
            n_fail++;
            $display("FAIL de_shape got run=%0d lines=%0d expected run=%0d lines=%0d",
                     max_run, rises, HA * CPP, VA);
        end
    endtask

    task automatic test_echo();
        int guard = 0;
        @(posedge i_clock); #1 alt_mode = 1'b0;
        repeat (FRAME) @(posedge i_clock);
        @(negedge i_clock);
        while (!(o_video_request === 1'b1 && o_video_pos_x === 9'd3 && o_video_pos_y === 9'd1)
               && guard < 2 * FRAME) begin
            @(negedge i_clock);
            guard++;
        end
        n_checks++;
        if (o_de !== 1'b1 || o_rgb !== {6'h0, 9'd1, 9'd2}) begin
            n_fail++;
            $display("FAIL echo_lag got de=%b rgb=%h expected de=1 rgb=%h",
                     o_de, o_rgb, {6'h0, 9'd1, 9'd2});
        end
    endtask

    task automatic test_alternating_rdata();
        @(posedge i_clock); #1 alt_mode = 1'b1;
        repeat (FRAME + LINE) @(posedge i_clock);
        #1 alt_mode = 1'b0;
        repeat (2 * CPP) @(posedge i_clock);
    endtask

    task automatic test_reset_midline();
        int guard = 0;
        @(negedge i_clock);
        while (!(o_video_pos_x === 9'd5 && o_video_pos_y === 9'd2) && guard < 2 * FRAME) begin
            @(negedge i_clock);
            guard++;
        end
        n_checks++;
        if (o_video_pos_x !== 9'd5 || o_video_pos_y !== 9'd2) begin
            n_fail++;
            $display("FAIL midline_reach got x=%0d y=%0d expected x=5 y=2", o_video_pos_x, o_video_pos_y);
        end
        @(posedge i_clock); #2 i_reset_n = 1'b0;
        #1 check_reset_values("midline_async_reset");
        repeat (2) @(posedge i_clock);
        #1 check_reset_values("midline_held_reset");
        release_and_check_start("midline");
    endtask

    task automatic test_vblank_irq();
        int   highs = 0;
        logic prev  = 1'b0;
        for (int g = 0; g < 2 * FRAME; g++) begin
            @(negedge i_clock);
            if (o_vblank_irq === 1'b1) begin
                highs++;
                n_checks++;
                if (prev === 1'b1 || cyc % FRAME != VA * HT * CPP) begin
                    n_fail++;
                    $display("FAIL irq_position got pulse at frame clock %0d (prev=%b) expected single clock at %0d",
                             cyc % FRAME, prev, VA * HT * CPP);
                end
            end
            prev = o_vblank_irq;
        end
        n_checks++;
`ifdef VIDEO_SCANOUT_IRQ_EN
        if (highs != 2) begin
            n_fail++;
            $display("FAIL irq_count got %0d high clocks in two frames expected 2", highs);
        end
`else
        if (highs != 0) begin
            n_fail++;
            $display("FAIL irq_count got %0d high clocks expected 0", highs);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sync_period();
        test_de_counts();
        test_echo();
        test_alternating_rdata();
        test_reset_midline();
        test_vblank_irq();
        repeat (2 * CPP) @(posedge i_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
